// File: rtl/pe_pkg.sv
// Shared constants for the processing element: default operand width, accumulator width, select encodings.
// Latency: n/a (package). Backpressure: none.
package pe_pkg;

    localparam int PE_N_DEFAULT = 8;

    // Operand-A mux selects: 0 picks the primary source, 1 the alternate.
    localparam logic MUX_SEL_PRIMARY = 1'b0;
    localparam logic MUX_SEL_ALT     = 1'b1;

    localparam logic ACC_SRC_PSUM = 1'b0;
    localparam logic ACC_SRC_ZERO = 1'b1;

    localparam logic OUT_REG    = 1'b0;
    localparam logic OUT_BYPASS = 1'b1;

    function automatic int acc_width(input int n);
        return 2 * n;
    endfunction

endpackage

// File: rtl/pe_mult.sv
// Unsigned N x N multiplier with full 2N-bit product.
// Latency: combinational. Backpressure: none.
module pe_mult #(
    parameter int N = 8
) (
    input  logic [N-1:0]   a_i,
    input  logic [N-1:0]   b_i,
    output logic [2*N-1:0] p_o
);

    assign p_o = {{N{1'b0}}, a_i} * {{N{1'b0}}, b_i};

endmodule

// File: rtl/processing_element.sv
// Three-tap MAC element with partial-sum accumulator; PE_SAT_ACC_EN selects saturating instead of wrapping sums.
// Latency: 1 clock registered output, 0 in bypass mode. Backpressure: none, accepts inputs every cycle.
module processing_element
    import pe_pkg::*;
#(
    parameter int N = PE_N_DEFAULT
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [N-1:0]   i0,
    input  logic [N-1:0]   i1,
    input  logic [N-1:0]   w0,
    input  logic [N-1:0]   w1,
    input  logic [N-1:0]   w2,
    input  logic           select_m0,
    input  logic           select_m1,
    input  logic           select_m2,
    input  logic           select_m3,
    input  logic           select0,
    input  logic           select1,
    output logic [2*N-1:0] out
);

    localparam int ACC_W = acc_width(N);

    logic [N-1:0]       r0_q, r1_q;
    logic [ACC_W-1:0]   psum_q, psum_d;
    logic [N-1:0]       a0, a1, a2;
    logic [ACC_W-1:0]   p0, p1, p2;
    logic [ACC_W-1:0]   base;
    logic [ACC_W+1:0]   sum;
    logic [ACC_W-1:0]   sum_red;

    assign a0 = (select_m0 == MUX_SEL_ALT) ? r1_q : i0;
    assign a1 = (select_m1 == MUX_SEL_ALT) ? r0_q : i1;
    assign a2 = (select_m2 == MUX_SEL_ALT) ? i0   : r1_q;

    pe_mult #(.N(N)) u_mult0 (.a_i(a0), .b_i(w0), .p_o(p0));
    pe_mult #(.N(N)) u_mult1 (.a_i(a1), .b_i(w1), .p_o(p1));
    pe_mult #(.N(N)) u_mult2 (.a_i(a2), .b_i(w2), .p_o(p2));

    assign base = (select_m3 == ACC_SRC_ZERO) ? '0 : psum_q;

    // Two guard bits: base plus three full-width products cannot exceed 4x max.
    assign sum = {2'b00, base} + {2'b00, p0} + {2'b00, p1} + {2'b00, p2};

`ifdef PE_SAT_ACC_EN
    assign sum_red = (|sum[ACC_W+1:ACC_W]) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    assign sum_red = ACC_W'(sum);
`endif

    always_comb begin
        psum_d = psum_q;
        if (select0) begin
            psum_d = sum_red;
        end
    end

    // Reset is active-high despite the port name.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            r0_q   <= '0;
            r1_q   <= '0;
            psum_q <= '0;
        end else begin
            r0_q   <= i0;
            r1_q   <= i1;
            psum_q <= psum_d;
        end
    end

    assign out = (select1 == OUT_BYPASS) ? sum_red : psum_q;

endmodule

// File: tb/tb_processing_element.sv
// Scoreboard bench for processing_element: directed vectors plus a randomized back-to-back run against a reference model.
module tb_processing_element;

    localparam int N = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [N-1:0]  i0, i1, w0, w1, w2;
    logic          select_m0, select_m1, select_m2, select_m3, select0, select1;
    logic [2*N-1:0] out;

    int checks = 0;
    int errors = 0;
    logic [2*N-1:0] sb[$];
    logic [2*N-1:0] exp_v;

    processing_element #(.N(N)) dut (
        .clk(clk), .reset_n(reset_n),
        .i0(i0), .i1(i1), .w0(w0), .w1(w1), .w2(w2),
        .select_m0(select_m0), .select_m1(select_m1), .select_m2(select_m2),
        .select_m3(select_m3), .select0(select0), .select1(select1),
        .out(out)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] red(input logic [17:0] s);
`ifdef PE_SAT_ACC_EN
        return (s >= 18'h10000) ? 16'hFFFF : s[15:0];
`else
        return s[15:0];
`endif
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b);
        i0 = a;
        i1 = b;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        select_m0 = 0; select_m1 = 0; select_m2 = 0; select_m3 = 0;
        select0 = 1; select1 = 0;
        i0 = 8'h55; i1 = 8'hAA; w0 = 8'h11; w1 = 8'h22; w2 = 8'h33;
        sb.push_back(16'h0000);
        cycle();
        exp_v = sb.pop_front();
        checks++;
        if (out !== exp_v) begin
            errors++;
            $display("FAIL reset_out: got %h expected %h", out, exp_v);
        end
        // Expose r0/r1 through the bypass path: A0=r1, A1=r0, A2=r1, base=0.
        select_m0 = 1; select_m1 = 1; select_m2 = 0; select_m3 = 1; select1 = 1;
        w0 = 1; w1 = 1; w2 = 1;
        sb.push_back(16'h0000);
        #1;
        exp_v = sb.pop_front();
        checks++;
        if (out !== exp_v) begin
            errors++;
            $display("FAIL reset_regs: got %h expected %h", out, exp_v);
        end
    endtask

    task automatic test_accumulate();
        logic [7:0] seq_i1 [3] = '{8'd2, 8'd3, 8'd4};
        logic [15:0] seq_exp [3] = '{16'd5, 16'd18, 16'd36};
        reset_n = 1'b0;
        select_m0 = 0; select_m1 = 0; select_m2 = 0; select_m3 = 0;
        select0 = 1; select1 = 0;
        w0 = 1; w1 = 2; w2 = 3;
        for (int k = 0; k < 3; k++) begin
            drive(8'd1, seq_i1[k]);
            sb.push_back(seq_exp[k]);
            cycle();
            exp_v = sb.pop_front();
            checks++;
            if (out !== exp_v) begin
                errors++;
                $display("FAIL accumulate[%0d]: got %0d expected %0d", k, out, exp_v);
            end
        end
    endtask

    task automatic test_hold();
        select0 = 0;
        drive(8'd9, 8'd9);
        for (int k = 0; k < 3; k++) begin
            sb.push_back(16'd36);
            cycle();
            exp_v = sb.pop_front();
            checks++;
            if (out !== exp_v) begin
                errors++;
                $display("FAIL hold[%0d]: got %0d expected %0d", k, out, exp_v);
            end
        end
    endtask

    task automatic test_restart();
        drive(8'd0, 8'd4);
        cycle();
        select_m3 = 1; select0 = 1;
        drive(8'd2, 8'd3);
        sb.push_back(16'd20);
        cycle();
        exp_v = sb.pop_front();
        checks++;
        if (out !== exp_v) begin
            errors++;
            $display("FAIL restart: got %0d expected %0d", out, exp_v);
        end
        // Restart request without accumulate enable must hold.
        select0 = 0;
        drive(8'd7, 8'd7);
        sb.push_back(16'd20);
        cycle();
        exp_v = sb.pop_front();
        checks++;
        if (out !== exp_v) begin
            errors++;
            $display("FAIL restart_hold: got %0d expected %0d", out, exp_v);
        end
    endtask

    task automatic test_wrap();
        // Build psum = 0xFFF0: 255*255 + 240*1 + r1(255)*1.
        select_m3 = 0; select0 = 0;
        drive(8'd0, 8'd255);
        cycle();
        select_m3 = 1; select0 = 1;
        w0 = 8'd255; w1 = 8'd1; w2 = 8'd1;
        drive(8'd255, 8'd240);
        sb.push_back(16'hFFF0);
        cycle();
        exp_v = sb.pop_front();
        checks++;
        if (out !== exp_v) begin
            errors++;
            $display("FAIL wrap_setup: got %h expected %h", out, exp_v);
        end
        // Add 0x20 on top of 0xFFF0.
        select_m3 = 0; w0 = 1; w1 = 0; w2 = 0;
        drive(8'h20, 8'd0);
        select1 = 1;
        sb.push_back(red(18'h10010));
        #1;
        exp_v = sb.pop_front();
        checks++;
        if (out !== exp_v) begin
            errors++;
            $display("FAIL wrap_bypass: got %h expected %h", out, exp_v);
        end
        select1 = 0;
        sb.push_back(red(18'h10010));
        cycle();
        exp_v = sb.pop_front();
        checks++;
        if (out !== exp_v) begin
            errors++;
            $display("FAIL wrap_reg: got %h expected %h", out, exp_v);
        end
    endtask

    task automatic test_bypass();
        select0 = 0;
        drive(8'd0, 8'd0);
        cycle();
        select_m0 = 0; select_m1 = 0; select_m2 = 0; select_m3 = 1;
        select0 = 1; select1 = 1;
        w0 = 1; w1 = 2; w2 = 3;
        drive(8'd1, 8'd2);
        sb.push_back(16'd5);
        #1;
        exp_v = sb.pop_front();
        checks++;
        if (out !== exp_v) begin
            errors++;
            $display("FAIL bypass_comb: got %0d expected %0d", out, exp_v);
        end
        cycle();
        select1 = 0;
        sb.push_back(16'd5);
        #1;
        exp_v = sb.pop_front();
        checks++;
        if (out !== exp_v) begin
            errors++;
            $display("FAIL bypass_psum: got %0d expected %0d", out, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  m_r0, m_r1, a0, a1, a2;
        logic [15:0] m_psum, base;
        logic [17:0] s;
        // Start from a known accumulator via reset.
        reset_n = 1'b1;
        cycle();
        reset_n = 1'b0;
        m_r0 = 0; m_r1 = 0; m_psum = 0;
        for (int k = 0; k < 60; k++) begin
            i0 = 8'($urandom); i1 = 8'($urandom);
            w0 = 8'($urandom); w1 = 8'($urandom); w2 = 8'($urandom);
            select_m0 = 1'($urandom); select_m1 = 1'($urandom); select_m2 = 1'($urandom);
            select_m3 = ($urandom_range(0, 3) == 0);
            select0 = ($urandom_range(0, 4) != 0);
            select1 = 1'($urandom);
            a0 = select_m0 ? m_r1 : i0;
            a1 = select_m1 ? m_r0 : i1;
            a2 = select_m2 ? i0 : m_r1;
            base = select_m3 ? 16'd0 : m_psum;
            s = 18'(base) + 18'(a0 * 16'(w0)) + 18'(16'(a1) * 16'(w1)) + 18'(16'(a2) * 16'(w2));
            sb.push_back(select1 ? red(s) : m_psum);
            #1;
            exp_v = sb.pop_front();
            checks++;
            if (out !== exp_v) begin
                errors++;
                $display("FAIL b2b[%0d]: got %h expected %h", k, out, exp_v);
            end
            cycle();
            m_r0 = i0; m_r1 = i1;
            if (select0) m_psum = red(s);
        end
        // Reset mid-accumulation discards psum regardless of selects.
        reset_n = 1'b1; select0 = 1; select_m3 = 0; select1 = 0;
        sb.push_back(16'h0000);
        cycle();
        exp_v = sb.pop_front();
        checks++;
        if (out !== exp_v) begin
            errors++;
            $display("FAIL reset_mid: got %h expected %h", out, exp_v);
        end
        reset_n = 1'b0;
    endtask

    initial begin
        test_reset();
        test_accumulate();
        test_hold();
        test_restart();
        test_wrap();
        test_bypass();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
